sonic_jtag_st_packet_arbiter: RTL
=================================

Name: sonic_jtag_st_packet_arbiter

Overview:
- Shares one Avalon-ST byte/packet stream between NUM_IN packet sources.
- Sits upstream of the JTAG-master bytes-to-packets channel adapter.
- Packet-granular round-robin arbitration, so a granted source keeps the stream from SOP through EOP.
- Tags each output beat with the winning source index on out_channel; drops and counts framing-error beats.

Parameters:
- NUM_IN, 4, number of requesters (2..8).
- DATA_W, 8, beat data width.
- CHANNEL_W, 8, out_channel width; must be >= clog2(NUM_IN).
- CNT_W, 16, width of the drop and packet counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  NUM_IN  per-source valid
- in_data  in  NUM_IN*DATA_W  per-source data, source i at [i*DATA_W +: DATA_W]
- in_startofpacket  in  NUM_IN  per-source SOP
- in_endofpacket  in  NUM_IN  per-source EOP
- in_ready  out  NUM_IN  per-source ready
- out_valid  out  1  registered output valid
- out_data  out  DATA_W  registered output data
- out_channel  out  CHANNEL_W  source index, zero-extended
- out_startofpacket  out  1  registered SOP
- out_endofpacket  out  1  registered EOP
- out_ready  in  1  downstream ready
- drop_count  out  CNT_W  beats discarded for framing errors (saturating)
- pkt_count  out  CNT_W  packets forwarded, counted on the accepted EOP beat (wraps)

Behaviour:
- Reset (reset_n low at a clk edge):
  - out_valid, out_data, out_channel, out_sop and out_eop = 0.
  - state = IDLE, last_grant = NUM_IN-1, so source 0 has first priority.
  - Both counters = 0.
  - Reset mid-packet abandons the packet; no EOP is emitted.
- Output stage:
  - One registered beat; stage_free = !out_valid || out_ready.
  - A beat accepted from a source at edge N appears on out_* after edge N, i.e. latency 1.
  - Back-to-back throughput is 1 beat/clk while out_ready = 1.
  - out_* is held stable while out_valid && !out_ready.
- in_ready is combinational:
  - Granted source: stage_free.
  - Sources dropping an error beat: 1.
  - All others: 0.
  - A source beat is accepted when in_valid[i] && in_ready[i].
- State IDLE:
  - Candidates are sources with in_valid && SOP.
  - Winner is the first candidate searching last_grant+1, +2, ... modulo NUM_IN.
  - If a winner exists and stage_free: accept its beat and set grant = winner.
  - Next state is BUSY, or stays IDLE if that beat also carries EOP (single-beat packet).
  - last_grant updates to the winner on the EOP beat.
  - If a winner exists but !stage_free: nothing is accepted, and the winner is re-evaluated next cycle.
- State BUSY:
  - Only the grant source may pass beats; its SOP bit is forwarded unchanged.
  - An accepted beat with EOP sets last_grant = grant and returns to IDLE.
  - No new grant is made in the EOP cycle; a new packet starts one cycle later at the earliest.
- Framing errors:
  - IDLE: any source with in_valid && !SOP is given in_ready = 1 and its beat discarded, in the same cycle as an arbitration win by another source.
  - BUSY: a grant-source beat with SOP = 1 (nested SOP) is forwarded as a new packet start. The old packet is considered truncated; no error is raised.
  - drop_count adds the number of discarded beats in the cycle and saturates at all-ones.
- pkt_count increments when an EOP beat is accepted into the output stage, wrapping modulo 2^CNT_W.
- out_channel = grant index; bits above clog2(NUM_IN) are 0.

Decomposition:
- Package sonic_jtag_st_pkg holds:
  - State enum {IDLE, BUSY}.
  - Function rr_pick(req, last) returning the index and a found flag.
  - Localparam IDX_W = clog2(NUM_IN).
- One sub-module is natural: sonic_jtag_st_out_reg, the single-entry registered ready/valid stage for data, channel, SOP and EOP.
- The arbiter FSM and counters stay in the top module.

Test Plan:
- Fairness:
  - Stimulus: NUM_IN=4; sources 0..3 each hold a 3-beat packet (data i*16+k) from cycle 0, out_ready = 1.
  - Required: out_channel sequence 0,0,0,1,1,1,2,2,2,3,3,3; one idle cycle after each EOP; pkt_count = 4.
- Single-beat packets:
  - Stimulus: sources 1 and 2 send SOP+EOP beats repeatedly.
  - Required: channels alternate 1,2,1,2 with no BUSY cycles; a beat appears 1 cycle after acceptance.
- Backpressure:
  - Stimulus: source 0 sends a 4-beat packet; out_ready is low for 3 cycles after beat 2.
  - Required: out_data holds beat 2 stable, in_ready[0] = 0 during the stall, no beat lost or duplicated.
- Framing drop:
  - Stimulus: in IDLE, source 3 drives valid without SOP for 5 cycles while source 0 sends a 2-beat packet.
  - Required: source 3 beats consumed and discarded; drop_count = 5; source 0 packet intact on channel 0.
- Reset mid-packet:
  - Stimulus: reset_n low for 1 cycle after beat 2 of a 6-beat packet from source 2.
  - Required: out_valid = 0 the next cycle; state IDLE; counters 0; the next packet is granted starting from source 0.
- Saturation:
  - Stimulus: CNT_W = 4, 20 dropped beats.
  - Required: drop_count stops at 15.

Source files
------------

// File: rtl/sonic_jtag_st_pkg.sv
// Shared types and the round-robin picker for the JTAG-master Avalon-ST packet arbiter.
package sonic_jtag_st_pkg;

    localparam int MAX_IN = 8;
    localparam int IDX_W  = $clog2(MAX_IN);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First requester after 'last', wrapping modulo num_in.
    function automatic pick_t rr_pick(input logic [MAX_IN-1:0] req,
                                      input logic [IDX_W-1:0]  last,
                                      input int                num_in);
        pick_t p;
        int    j;
        p.found = 1'b0;
        p.idx   = '0;
        for (int k = 1; k <= MAX_IN; k++) begin
            if (k <= num_in) begin
                j = (int'(last) + k) % num_in;
                if (!p.found && req[IDX_W'(j)]) begin
                    p.found = 1'b1;
                    p.idx   = IDX_W'(j);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/sonic_jtag_st_out_reg.sv
// Single-entry registered ready/valid stage carrying data, channel and packet framing.
module sonic_jtag_st_out_reg #(
    parameter int DATA_W    = 8,
    parameter int CHANNEL_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [DATA_W-1:0]    load_data,
    input  logic [CHANNEL_W-1:0] load_channel,
    input  logic                 load_sop,
    input  logic                 load_eop,
    output logic                 stage_free,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic [CHANNEL_W-1:0] out_channel,
    output logic                 out_startofpacket,
    output logic                 out_endofpacket,
    input  logic                 out_ready
);

    assign stage_free = !out_valid || out_ready;

    // Output beat register; load is only raised while stage_free holds.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_channel       <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
        end else if (load) begin
            out_valid         <= 1'b1;
            out_data          <= load_data;
            out_channel       <= load_channel;
            out_startofpacket <= load_sop;
            out_endofpacket   <= load_eop;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sonic_jtag_st_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_IN Avalon-ST sources into one channel-tagged stream.
module sonic_jtag_st_packet_arbiter
    import sonic_jtag_st_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int DATA_W    = 8,
    parameter int CHANNEL_W = 8,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_startofpacket,
    input  logic [NUM_IN-1:0]        in_endofpacket,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CHANNEL_W-1:0]     out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         drop_count,
    output logic [CNT_W-1:0]         pkt_count
);

    state_t                   state, state_nx;
    logic [IDX_W-1:0]         grant, grant_nx;
    logic [IDX_W-1:0]         last_grant, last_grant_nx;
    logic [IDX_W-1:0]         sel;
    logic [MAX_IN-1:0]        valid_x, sop_x, eop_x;
    logic [MAX_IN*DATA_W-1:0] data_x;
    logic [NUM_IN-1:0]        drop_mask;
    logic [3:0]               drop_n;
    logic [CNT_W:0]           drop_sum;
    logic                     stage_free;
    logic                     load;
    pick_t                    pick;

    // Widen per-source vectors so a full-width index never runs off the end.
    assign valid_x = MAX_IN'(in_valid);
    assign sop_x   = MAX_IN'(in_startofpacket);
    assign eop_x   = MAX_IN'(in_endofpacket);
    assign data_x  = (MAX_IN*DATA_W)'(in_data);

    always_comb begin
        pick          = rr_pick(MAX_IN'(in_valid & in_startofpacket), last_grant, NUM_IN);
        state_nx      = state;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        sel           = grant;
        load          = 1'b0;
        drop_mask     = '0;
        in_ready      = '0;
        case (state)
            IDLE: begin
                // Beats without SOP cannot start a packet; swallow them.
                drop_mask = in_valid & ~in_startofpacket;
                if (pick.found) begin
                    sel  = pick.idx;
                    load = stage_free;
                end
            end
            BUSY: begin
                load = stage_free && valid_x[grant];
            end
            default: ;
        endcase
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = drop_mask[i] ||
                          (sel == IDX_W'(i) && stage_free && (state == BUSY || pick.found));
        end
        if (load) begin
            if (eop_x[sel]) begin
                state_nx      = IDLE;
                last_grant_nx = sel;
            end else begin
                state_nx = BUSY;
                grant_nx = sel;
            end
        end
    end

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            drop_n = drop_n + 4'(drop_mask[i]);
        end
    end

    assign drop_sum = {1'b0, drop_count} + (CNT_W+1)'(drop_n);

    // Arbiter state and counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_IN-1);
            drop_count <= '0;
            pkt_count  <= '0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_grant_nx;
            drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            if (load && eop_x[sel]) begin
                pkt_count <= pkt_count + CNT_W'(1);
            end
        end
    end

    sonic_jtag_st_out_reg #(
        .DATA_W    (DATA_W),
        .CHANNEL_W (CHANNEL_W)
    ) u_out_reg (
        .clk               (clk),
        .reset_n           (reset_n),
        .load              (load),
        .load_data         (data_x[sel*DATA_W +: DATA_W]),
        .load_channel      (CHANNEL_W'(sel)),
        .load_sop          (sop_x[sel]),
        .load_eop          (eop_x[sel]),
        .stage_free        (stage_free),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_ready         (out_ready)
    );

endmodule
